// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the width of the step counter.
package seq_restoring_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // The counter has to hold WIDTH-1.
    function automatic int count_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One combinational restoring-division step: shift {A,Q} left by one, then
// trial-subtract M and keep the difference only when it is non-negative.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   a_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH-1:0] q_out
);

    // One extra bit beyond the shifted A, so the MSB acts as the sign of the trial.
    logic [WIDTH+1:0] trial;

    assign trial = {a_in, q_in[WIDTH-1]} - {2'b00, m};

    always_comb begin
        a_out = {a_in[WIDTH-1:0], q_in[WIDTH-1]};
        q_out = {q_in[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH+1]) begin
            a_out    = trial[WIDTH:0];
            q_out[0] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV0_FAST_EN: a zero divisor finishes in one cycle and sets div_by_zero.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = count_width(WIDTH);

    div_state_t       state, state_nxt;
    logic [WIDTH:0]   a_r, a_step;
    logic [WIDTH-1:0] q_r, m_r, q_step;
    logic [CW-1:0]    count;
    logic             zero_fast;

`ifdef DIV0_FAST_EN
    logic dbz_r;
    assign zero_fast   = (divisor == '0);
    assign div_by_zero = dbz_r;
`else
    assign zero_fast   = 1'b0;
    assign div_by_zero = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .a_in  (a_r),
        .q_in  (q_r),
        .m     (m_r),
        .a_out (a_step),
        .q_out (q_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = zero_fast ? DONE : RUN;
            RUN:     if (count == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r       <= '0;
            q_r       <= '0;
            m_r       <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV0_FAST_EN
            dbz_r     <= 1'b0;
`endif
        end else if (state == IDLE && start) begin
            a_r   <= '0;
            q_r   <= dividend;
            m_r   <= divisor;
            count <= CW'(WIDTH - 1);
            if (zero_fast) begin
                quotient  <= '1;
                remainder <= dividend;
`ifdef DIV0_FAST_EN
                dbz_r     <= 1'b1;
`endif
            end
        end else if (state == RUN) begin
            a_r   <= a_step;
            q_r   <= q_step;
            count <= count - CW'(1);
            if (count == '0) begin
                quotient  <= q_step;
                remainder <= a_step[WIDTH-1:0];
`ifdef DIV0_FAST_EN
                dbz_r     <= 1'b0;
`endif
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
